// File: rtl/tx_engine.sv
// UART transmit engine: start bit, 7/8 data bits LSB first, optional parity, stop bit(s).
// Define TX_TWO_STOP_EN to append a second stop bit (STOP2) before returning to idle.
module tx_engine #(
    parameter int BR_W   = 20,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] out_port,
    input  logic              bit8,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BR_W-1:0]   br,
    output logic              tx,
    output logic              txrdy
);

`ifdef TX_TWO_STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BR_W-1:0]     cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                bit8_q, bit8_d;
    logic                pen_q, pen_d;
    logic                par_q, par_d;
    logic [BR_W-1:0]     br_q, br_d;

    logic                accept;
    logic                bit_end;
    logic [BR_W-1:0]     br_eff;
    logic [2:0]          last_idx;
    logic [DATA_W-1:0]   data_sel;

    assign accept   = load && (state_q == IDLE);
    assign br_eff   = (br_q == '0) ? BR_W'(1) : br_q;
    assign bit_end  = (cnt_q == br_eff);
    assign last_idx = bit8_q ? 3'd7 : 3'd6;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            bit8_q  <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            bit8_q  <= bit8_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (load) state_d = START;
            START:  if (bit_end) state_d = DATA;
            DATA:   if (bit_end && (idx_q == last_idx)) state_d = pen_q ? PARITY : STOP;
            PARITY: if (bit_end) state_d = STOP;
`ifdef TX_TWO_STOP_EN
            STOP:   if (bit_end) state_d = STOP2;
            STOP2:  if (bit_end) state_d = IDLE;
`else
            STOP:   if (bit_end) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Parity is folded at load time from the data bits actually sent, so only par_q is kept.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        bit8_d   = bit8_q;
        pen_d    = pen_q;
        par_d    = par_q;
        br_d     = br_q;
        data_sel = out_port;
        if (!bit8) data_sel[DATA_W-1] = 1'b0;
        if (accept) begin
            shift_d = out_port;
            bit8_d  = bit8;
            pen_d   = pen;
            par_d   = (^data_sel) ^ ohel;
            br_d    = br;
            cnt_d   = BR_W'(1);
            idx_d   = 3'd0;
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                cnt_d = BR_W'(1);
                if (state_q == DATA) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + BR_W'(1);
            end
        end
    end

    always_comb begin
        tx    = 1'b1;
        txrdy = 1'b0;
        case (state_q)
            IDLE:    txrdy = 1'b1;
            START:   tx    = 1'b0;
            DATA:    tx    = shift_q[0];
            PARITY:  tx    = par_q;
            default: tx    = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tx_engine.sv
// Directed bench for tx_engine: checks every bit's first and last clock against hand-built frames.
// Honours TX_TWO_STOP_EN by extending each expected frame with one more stop bit.
module tb_tx_engine;

    logic        clk;
    logic        reset;
    logic        load;
    logic [7:0]  out_port;
    logic        bit8;
    logic        pen;
    logic        ohel;
    logic [19:0] br;
    logic        tx;
    logic        txrdy;

    int checkCount = 0;
    int passCount  = 0;

    tx_engine #(.BR_W(20), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .out_port (out_port),
        .bit8     (bit8),
        .pen      (pen),
        .ohel     (ohel),
        .br       (br),
        .tx       (tx),
        .txrdy    (txrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    // Called at a negedge; frame bits are listed LSB = start bit. busyAt injects a load plus
    // scrambled config at that sample index while the frame is in flight.
    task automatic applyStimulus(input logic [7:0] data, input logic b8, input logic p, input logic o,
                                 input logic [19:0] brv, input logic [15:0] expBits,
                                 input int nBits, input int busyAt, input string name);
        int brEff;
        int bitIdx;
        brEff = (brv == 0) ? 1 : int'(brv);
`ifdef TX_TWO_STOP_EN
        expBits[nBits] = 1'b1;
        nBits++;
`endif
        out_port = data; bit8 = b8; pen = p; ohel = o; br = brv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < nBits * brEff; k++) begin
            bitIdx = k / brEff;
            if ((k % brEff == 0) || (k % brEff == brEff - 1))
                checkOutput($sformatf("%s_tx_bit%0d_s%0d", name, bitIdx, k), {31'd0, tx}, {31'd0, expBits[bitIdx]});
            if ((k == 0) || (k == nBits * brEff - 1))
                checkOutput($sformatf("%s_txrdy_busy_s%0d", name, k), {31'd0, txrdy}, 32'd0);
            if (k == busyAt) begin
                load = 1'b1; out_port = 8'hFF; bit8 = ~b8; pen = ~p; ohel = ~o; br = brv + 20'd7;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        checkOutput({name, "_tx_idle"}, {31'd0, tx}, 32'd1);
        checkOutput({name, "_txrdy_idle"}, {31'd0, txrdy}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; load = 1'b1; out_port = 8'h00; bit8 = 1'b1; pen = 1'b0; ohel = 1'b0; br = 20'd109;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_txrdy", {31'd0, txrdy}, 32'd1);
        reset = 1'b1; load = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_tx", {31'd0, tx}, 32'd1);

        $display("[TB] odd parity 8-bit 0x55");
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b1, 20'd109, 16'b1_1_01010101_0, 11, -1, "t1");

        $display("[TB] even parity 0xA7");
        applyStimulus(8'hA7, 1'b1, 1'b1, 1'b0, 20'd109, 16'b1_1_10100111_0, 11, -1, "t2");

        $display("[TB] 7-bit no parity 0x80");
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b0, 20'd109, 16'b1_0000000_0, 9, -1, "t3");

        $display("[TB] busy load and back-to-back");
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0, 20'd109, 16'b1_00010010_0, 10, 500, "t4a");
        applyStimulus(8'h34, 1'b1, 1'b0, 1'b0, 20'd109, 16'b1_00110100_0, 10, 10 * 109 - 1, "t4b");

        $display("[TB] mid-frame reset");
        repeat (2) @(negedge clk);
        out_port = 8'h3C; bit8 = 1'b1; pen = 1'b0; ohel = 1'b0; br = 20'd109; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (300) @(negedge clk);
        reset = 1'b0; load = 1'b1;
        @(negedge clk);
        checkOutput("t5_tx_reset", {31'd0, tx}, 32'd1);
        checkOutput("t5_txrdy_reset", {31'd0, txrdy}, 32'd1);
        reset = 1'b1; load = 1'b0;
        repeat (150) @(negedge clk);
        checkOutput("t5_tx_no_resume", {31'd0, tx}, 32'd1);
        checkOutput("t5_txrdy_no_resume", {31'd0, txrdy}, 32'd1);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 20'd109, 16'b1_00111100_0, 10, -1, "t5");

        $display("[TB] br=1 and br=0");
        @(negedge clk);
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b1, 20'd1, 16'b1_1_01010101_0, 11, -1, "t6a");
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b1, 20'd0, 16'b1_1_01010101_0, 11, -1, "t6b");
        applyStimulus(8'hC3, 1'b0, 1'b1, 1'b0, 20'd0, 16'b1_1_1000011_0, 10, 3, "t6c");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
